// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared state, mux-select, ALU-op and opcode constants for the multicycle controller
package riscv_mc_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_IMM    = 2'b01;
  localparam logic [1:0] SRC_B_FOUR   = 2'b10;
  localparam logic [1:0] RES_ALU_OUT  = 2'b00;
  localparam logic [1:0] RES_READ     = 2'b01;
  localparam logic [1:0] RES_ALU      = 2'b10;
  localparam logic [1:0] RES_IMM      = 2'b11;
  localparam logic [1:0] IMM_I        = 2'b00;
  localparam logic [1:0] IMM_S        = 2'b01;
  localparam logic [1:0] IMM_B        = 2'b10;
  localparam logic [1:0] IMM_JU       = 2'b11;
  localparam logic [1:0] ALU_ADD      = 2'b00;
  localparam logic [1:0] ALU_SUB      = 2'b01;
  localparam logic [1:0] ALU_FUNCT    = 2'b10;
  localparam logic [6:0] OP_LW        = 7'b0000011;
  localparam logic [6:0] OP_SW        = 7'b0100011;
  localparam logic [6:0] OP_R         = 7'b0110011;
  localparam logic [6:0] OP_I         = 7'b0010011;
  localparam logic [6:0] OP_BEQ       = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  function automatic logic op_legal(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I ||
           op == OP_BEQ || op == OP_JAL || op == OP_LUI;
  endfunction
endpackage

// File: rtl/riscv_imm_decoder.sv
// riscv_imm_decoder: combinational immediate-format select from the opcode
module riscv_imm_decoder
  import riscv_mc_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);
  assign imm_src = op == OP_SW  ? IMM_S :
                   op == OP_BEQ ? IMM_B :
                   (op == OP_JAL || op == OP_LUI) ? IMM_JU : IMM_I;
endmodule

// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RISC-V control FSM with memory handshake and decoded datapath controls
module riscv_mc_controller
  import riscv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t cur, nxt;
  always_ff @(posedge clk) cur <= reset ? S_FETCH : nxt;
  assign state = cur;
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   nxt = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                        op == OP_R   ? S_EXECR :
                        op == OP_I   ? S_EXECI :
                        op == OP_BEQ ? S_BEQ   :
                        op == OP_JAL ? S_JAL   :
                        op == OP_LUI ? S_LUI   : S_FETCH;
      S_MEMADR:   nxt = op == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  nxt = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: nxt = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: nxt = S_ALUWB;
      default:    nxt = S_FETCH;
    endcase
  end
  always_comb begin
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALU_OUT;
    case (cur)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMADR, S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = cur == S_EXECI ? ALU_FUNCT : ALU_ADD;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_BEQ: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_SUB;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
      end
      S_MEMWB:  result_src = RES_READ;
      S_LUI:    result_src = RES_IMM;
      default:  result_src = RES_ALU_OUT;
    endcase
  end
  // enables are forced low during reset so a stalled access is abandoned cleanly
  assign mem_req    = !reset && (cur == S_FETCH || cur == S_MEMREAD || cur == S_MEMWRITE);
  assign adr_src    = cur == S_MEMREAD || cur == S_MEMWRITE;
  assign ir_write   = !reset && cur == S_FETCH && mem_ready;
  assign pc_write   = !reset && ((cur == S_FETCH && mem_ready) || (cur == S_BEQ && zero) || cur == S_JAL);
  assign reg_write  = !reset && (cur == S_MEMWB || cur == S_ALUWB || cur == S_LUI);
  assign mem_write  = !reset && cur == S_MEMWRITE;
  assign illegal_op = !reset && cur == S_DECODE && !op_legal(op);
  riscv_imm_decoder u_imm (.op(op), .imm_src(imm_src));
endmodule
